// File: rtl/video_timing_pkg.sv
// Shared video timing types and default 640x480 constants.
// Used by the horizontal and vertical timing stages.
package video_timing_pkg;

  typedef enum logic [1:0] {
    ACTIVE,
    FRONT,
    SYNC,
    BACK
  } phase_t;

  localparam int H_ACTIVE_640 = 640;
  localparam int H_FP_640     = 16;
  localparam int H_SYNC_640   = 96;
  localparam int H_BP_640     = 48;

  function automatic int max4(
    input int a,
    input int b,
    input int c,
    input int d
  );
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

endpackage

// File: rtl/hs_timing_gen.sv
// Horizontal timing generator: phases, hsync, de, x.
// Issues a one-clock line_end strobe for the vs stage.
module hs_timing_gen
  import video_timing_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_640,
  parameter int H_FP     = H_FP_640,
  parameter int H_SYNC   = H_SYNC_640,
  parameter int H_BP     = H_BP_640,
  parameter int HS_POL   = 0,
  parameter int XW       = $clog2(H_ACTIVE)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          restart,
  output logic          hsync,
  output logic          de,
  output logic [XW-1:0] x,
  output logic          line_end
);

  if (H_ACTIVE < 2 || H_FP < 1 ||
      H_SYNC < 1 || H_BP < 1) begin : g_param_err
    $error("hs_timing_gen: bad timing params");
  end

  localparam int H_MAX =
    max4(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int CW = $clog2(H_MAX);

  localparam logic [CW-1:0] A_LAST =
    CW'(H_ACTIVE - 1);
  localparam logic [CW-1:0] F_LAST =
    CW'(H_FP - 1);
  localparam logic [CW-1:0] S_LAST =
    CW'(H_SYNC - 1);
  localparam logic [CW-1:0] B_LAST =
    CW'(H_BP - 1);

  localparam logic HS_ON  = (HS_POL != 0);
  localparam logic HS_OFF = ~HS_ON;

  phase_t          r_phase;
  logic [CW-1:0]   r_cnt;
  phase_t          w_nxt_phase;
  phase_t          w_step_phase;
  logic [CW-1:0]   w_nxt_cnt;
  logic            w_last;
  logic            w_clr;

  assign w_clr = ~rst | restart;

  // Next position: advance cnt, step phase at its last pixel.
  always_comb begin
    w_last       = 1'b0;
    w_step_phase = ACTIVE;
    w_nxt_phase  = r_phase;
    w_nxt_cnt    = r_cnt;
    unique case (r_phase)
      ACTIVE: begin
        w_last       = (r_cnt == A_LAST);
        w_step_phase = FRONT;
      end
      FRONT: begin
        w_last       = (r_cnt == F_LAST);
        w_step_phase = SYNC;
      end
      SYNC: begin
        w_last       = (r_cnt == S_LAST);
        w_step_phase = BACK;
      end
      BACK: begin
        w_last       = (r_cnt == B_LAST);
        w_step_phase = ACTIVE;
      end
      default: begin
        w_last       = 1'b1;
        w_step_phase = ACTIVE;
      end
    endcase
    if (en) begin
      if (w_last) begin
        w_nxt_phase = w_step_phase;
        w_nxt_cnt   = '0;
      end else begin
        w_nxt_cnt   = r_cnt + 1'b1;
      end
    end
  end

  // Position register; reset and restart realign to ACTIVE/0.
  always_ff @(posedge clk) begin
    if (w_clr) begin
      r_phase <= ACTIVE;
      r_cnt   <= '0;
    end else begin
      r_phase <= w_nxt_phase;
      r_cnt   <= w_nxt_cnt;
    end
  end

  // Registered outputs describe the pixel issued on this en tick.
  always_ff @(posedge clk) begin
    if (w_clr) begin
      de       <= 1'b0;
      x        <= '0;
      hsync    <= HS_OFF;
      line_end <= 1'b0;
    end else if (en) begin
      de       <= (r_phase == ACTIVE);
      x        <= (r_phase == ACTIVE) ?
                  r_cnt[XW-1:0] : '0;
      hsync    <= (r_phase == SYNC) ?
                  HS_ON : HS_OFF;
      line_end <= (r_phase == BACK) & w_last;
    end else begin
      line_end <= 1'b0;
    end
  end

endmodule

// File: tb/tb_hs_timing_gen.sv
// Directed bench for hs_timing_gen, 8/2/3/2 line.
// Runs an active-low and an active-high hsync build.
module tb_hs_timing_gen;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en = 1'b0;
  logic       restart = 1'b0;

  logic       hs0, de0, le0;
  logic [2:0] x0;
  logic       hs1, de1, le1;
  logic [2:0] x1;

  int n_run  = 0;
  int n_fail = 0;

  // bench reference: flat pixel index within the line
  int  p = 0;
  int  m_de = 0, m_x = 0, m_hs = 1, m_le = 0;
  int  hs1_cnt = 0;
  int  le_cnt = 0;

  always #5 clk = ~clk;

  hs_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3),
    .H_BP(2), .HS_POL(0)
  ) u_dut0 (
    .clk(clk), .rst(rst), .en(en),
    .restart(restart), .hsync(hs0),
    .de(de0), .x(x0), .line_end(le0)
  );

  hs_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3),
    .H_BP(2), .HS_POL(1)
  ) u_dut1 (
    .clk(clk), .rst(rst), .en(en),
    .restart(restart), .hsync(hs1),
    .de(de1), .x(x1), .line_end(le1)
  );

  task automatic chk(
    input string tag,
    input int    got,
    input int    exp
  );
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d want %0d @%0t",
               tag, got, exp, $time);
    end
  endtask

  // Drive one clock, update the reference, check both builds.
  task automatic step(
    input logic r,
    input logic rs,
    input logic e
  );
    rst = r;
    restart = rs;
    en = e;
    @(posedge clk);
    if (!r || rs) begin
      m_de = 0; m_x = 0; m_hs = 1; m_le = 0;
      p = 0;
    end else if (e) begin
      m_de = (p < 8) ? 1 : 0;
      m_x  = (p < 8) ? p : 0;
      m_hs = (p >= 10 && p <= 12) ? 0 : 1;
      m_le = (p == 14) ? 1 : 0;
      p = (p + 1) % 15;
    end else begin
      m_le = 0;
    end
    #1;
    chk("de0", int'(de0), m_de);
    chk("x0", int'(x0), m_x);
    chk("hs0", int'(hs0), m_hs);
    chk("le0", int'(le0), m_le);
    chk("de1", int'(de1), m_de);
    chk("x1", int'(x1), m_x);
    chk("hs1", int'(hs1), 1 - m_hs);
    chk("le1", int'(le1), m_le);
    if (hs1) hs1_cnt++;
    if (le0) le_cnt++;
  endtask

  initial begin
    // reset held for three clocks
    for (int i = 0; i < 3; i++) step(0, 0, 1);

    // two full lines, en continuous
    hs1_cnt = 0;
    le_cnt = 0;
    for (int i = 0; i < 15; i++) step(1, 0, 1);
    chk("hs1_width", hs1_cnt, 3);
    for (int i = 0; i < 15; i++) step(1, 0, 1);
    chk("le_cont", le_cnt, 2);

    // en every other cycle: two lines in 60 clocks
    le_cnt = 0;
    for (int i = 0; i < 60; i++)
      step(1, 0, (i % 2 == 0) ? 1'b1 : 1'b0);
    chk("le_toggle", le_cnt, 2);

    // restart in sync phase, cnt=1
    for (int i = 0; i < 11; i++) step(1, 0, 1);
    chk("pre_rs_hs0", int'(hs0), 0);
    step(1, 1, 1);
    chk("rs_hs0", int'(hs0), 1);
    chk("rs_de0", int'(de0), 0);
    step(1, 0, 1);
    chk("rs_next_de", int'(de0), 1);
    chk("rs_next_x", int'(x0), 0);

    // restart on the line_end cycle suppresses it
    for (int i = 0; i < 13; i++) step(1, 0, 1);
    step(1, 1, 1);
    chk("rs_le", int'(le0), 0);

    // rst during x=5
    for (int i = 0; i < 6; i++) step(1, 0, 1);
    chk("pre_rst_x", int'(x0), 5);
    step(0, 0, 1);
    chk("rst_de", int'(de0), 0);
    step(1, 0, 1);
    chk("rst_rel_de", int'(de0), 1);
    chk("rst_rel_x", int'(x0), 0);

    // settle a further line after recovery
    le_cnt = 0;
    for (int i = 0; i < 15; i++) step(1, 0, 1);
    chk("le_after", le_cnt, 1);

    $display("[TB] %0d tests run, %0d failed",
             n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/hs_timing_gen.md
Name: hs_timing_gen

Overview:
- Horizontal video timing generator. Sits directly upstream of the vertical sync stage (vs) and feeds it the per-line end pulse it counts lines on.
- Walks each line through active, front-porch, sync and back-porch phases on a pixel enable.
- Emits hsync, data-enable and pixel x coordinate.
- Emits a one-clock line_end strobe consumed by vs.

Parameters:
- H_ACTIVE, 640, active pixels per line
- H_FP, 16, front-porch pixels
- H_SYNC, 96, sync-pulse pixels
- H_BP, 48, back-porch pixels
- HS_POL, 0, hsync active level (0 = active-low, 1 = active-high)
- XW, $clog2(H_ACTIVE), width of x output

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous, active-low reset
- en  in  1  pixel tick; position advances only on cycles with en=1
- restart  in  1  synchronous realign pulse; forces start of line
- hsync  out  1  horizontal sync at HS_POL level during sync phase
- de  out  1  high during active pixels
- x  out  XW  active pixel index 0..H_ACTIVE-1; 0 during blanking
- line_end  out  1  one-clk strobe after last pixel of a line, to vs

Behaviour:
- Reset and clocking
  - One clock, clk.
  - rst is synchronous and active-low: sampled on the rising edge of clk; rst=0 resets.
- Internal position
  - Position is phase register {ACTIVE, FRONT, SYNC, BACK} plus phase counter cnt (width to hold max phase length - 1).
  - The position register always points at the next pixel to issue.
- Reset (rst=0 at a clk edge)
  - Position resets to ACTIVE, cnt=0.
  - Outputs reset to de=0, x=0, line_end=0, hsync=~HS_POL (inactive).
- Cycle with en=1 (and no restart)
  - Outputs are registered from the current position:
    - de = (phase==ACTIVE)
    - x = cnt when ACTIVE, else 0
    - hsync = HS_POL when SYNC, else ~HS_POL
  - Position then advances:
    - cnt increments.
    - When cnt reaches phase length - 1, cnt returns to 0 and the phase steps ACTIVE->FRONT->SYNC->BACK->ACTIVE.
- Latency
  - Outputs reflect a pixel one clk after the en that issued it.
  - hsync, de and x hold their values between en cycles.
- line_end
  - Asserted for exactly one clk: the cycle after the en that issued BACK, cnt=H_BP-1.
  - Low on every other cycle, even when en stays high.
- Line period
  - H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP en ticks.
  - Wrap-around from the last back-porch pixel to ACTIVE/0 is seamless: no idle tick.
- restart=1 (with rst=1)
  - Next edge: position becomes ACTIVE/0.
  - Outputs take their reset values: de=0, x=0, hsync inactive, line_end=0.
  - restart together with en: restart wins and that en tick is dropped.
  - restart on the cycle that would raise line_end: line_end stays low.
- Priority: rst over restart over en.
- en=0 for any number of cycles: no state or output change; line_end stays 0.
- Parameter checks
  - Every phase length must be >= 1.
  - H_ACTIVE must be >= 2.
  - A violation is an elaboration-time error; zero-length phases are not supported.
- Arithmetic: x and cnt are unsigned with no overflow; cnt never exceeds phase length - 1 by construction.

Decomposition:
- Shared package video_timing_pkg holds:
  - phase enum {ACTIVE, FRONT, SYNC, BACK}
  - default 640x480 horizontal constants, shared with the vs stage
- No sub-module; a single always block plus output registers is sufficient.

Test Plan:
- Reset and first pixel:
  - Stimulus: H_ACTIVE=8, H_FP=2, H_SYNC=3, H_BP=2 (H_TOTAL=15), HS_POL=0; hold rst=0 for 3 clks, then release with en=1 continuously.
  - Required: during reset de=0, hsync=1, x=0, line_end=0; first clk after the first en gives de=1, x=0.
- Full line with en=1 continuous:
  - de high for 8 clks with x=0..7.
  - Then 2 clks de=0, hsync=1; then 3 clks hsync=0; then 2 clks hsync=1.
  - line_end pulses once on clk 15.
  - Pattern repeats every 15 clks.
- en toggled every other cycle:
  - All phase widths double to 16, 4, 6, 4 clks.
  - line_end stays a single-clk pulse every 30 clks.
- restart mid-sync (cnt=1) with en=1:
  - Next clk: hsync=1, de=0.
  - Following clk: de=1, x=0.
  - No line_end for the aborted line.
- rst=0 asserted during active pixel x=5:
  - Outputs go to reset values on the next edge.
  - After release the line restarts at x=0.
- HS_POL=1 build: hsync=0 outside the sync phase and 1 for exactly 3 en ticks per line.
